// File: rtl/i2c_pkg.sv
// Shared I2C subordinate definitions: protocol state encoding, bit-slot
// constants and small decode helpers. The memory interface and its state
// machine import the same package, so these encodings must not change.
package i2c_pkg;

  // Protocol state. Encodings 8..15 are unused and are forced back to IDLE.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR       = 4'd1,
    ADDR_ACK   = 4'd2,
    WRITE_DATA = 4'd3,
    WRITE_ACK  = 4'd4,
    READ_DATA  = 4'd5,
    READ_ACK   = 4'd6,
    IGNORE     = 4'd7
  } i2c_state_t;

  // Bit-slot numbering within a byte: 0..7 carry data MSB first, 8 is ACK.
  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_ACK  = 4'd8;

  // The subordinate owns SDA in both ACK slots it generates and while it
  // shifts read data out to the controller.
  function automatic logic drives_sda(input i2c_state_t s);
    return (s == ADDR_ACK) || (s == WRITE_ACK) || (s == READ_DATA);
  endfunction

  // States in which an SCL rise samples SDA into the receive shift register.
  function automatic logic shifts_in(input i2c_state_t s);
    return (s == ADDR) || (s == WRITE_DATA);
  endfunction

  // States in which SCL falls advance the bit-slot counter.
  function automatic logic counts_bits(input i2c_state_t s);
    return (s == ADDR) || (s == WRITE_DATA) || (s == READ_DATA);
  endfunction

  // True for the eight defined encodings.
  function automatic logic is_valid_state(input i2c_state_t s);
    return s <= IGNORE;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers and bus event detection. Produces the synchronized
// SDA level plus single-cycle SCL edge strobes and START/STOP strobes.
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   sda_rise;
  logic                   sda_fall;

  // Shift the raw pins through the synchronizer chains and keep one-cycle
  // delayed copies of the synchronized levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all flops reset to 1 (idle bus) so that releasing reset never
      // looks like an SDA fall with SCL high, i.e. a false START.
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a real shift chain.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise_o = scl_s & ~scl_dly_q;
  assign scl_fall_o = ~scl_s & scl_dly_q;
  assign sda_rise   = sda_s & ~sda_dly_q;
  assign sda_fall   = ~sda_s & sda_dly_q;

  // SDA may only change while SCL is low during data; a change with SCL
  // high is a bus condition.
  assign start_o = sda_fall & scl_s;
  assign stop_o  = sda_rise & scl_s;
  assign sda_s_o = sda_s;

endmodule

// File: rtl/i2c_protocol_fsm.sv
// Bus-level front end of the I2C subordinate. Tracks the protocol state and
// bit slot, matches the 7-bit address, latches the R/W direction and drives
// the address ACK. All outputs are registered.
module i2c_protocol_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [3:0] i2c_state,
  output logic [3:0] clock_count,
  output logic       read_bit,
  output logic       write_bit,
  output logic       sda_en,
  output logic       addr_ack,
  output logic       start_det,
  output logic       stop_det
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_s_o   (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (bus_start),
    .stop_o    (bus_stop)
  );

  i2c_state_t state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [7:0] shreg_q, shreg_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic       mack_q, mack_d;
  logic       skip_fall_q, skip_fall_d;
  logic       sda_en_q, addr_ack_q;
  logic       start_det_q, stop_det_q;

  // Next-state logic: bus conditions first (STOP over START), then SCL fall
  // transitions, then SCL rise sampling.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so a path that
    // does not assign it holds the register instead of inferring a latch.
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    read_d      = read_q;
    write_d     = write_q;
    mack_d      = mack_q;
    skip_fall_d = skip_fall_q;

    if (bus_stop) begin
      state_d     = IDLE;
      count_d     = '0;
      read_d      = 1'b0;
      write_d     = 1'b0;
      skip_fall_d = 1'b0;
    end else if (bus_start) begin
      // Direction bits hold until the next address match.
      state_d     = ADDR;
      count_d     = '0;
      shreg_d     = '0;
      skip_fall_d = 1'b1;
    end else if (scl_fall) begin
      if (skip_fall_q) begin
        // The SCL fall that completes a (repeated) START only opens slot 0
        // of the address byte; it does not close a bit slot.
        skip_fall_d = 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            count_d = count_q + 4'd1;
            if (count_q == BIT_LAST) begin
              if (shreg_q[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                read_d  = shreg_q[0];
                write_d = ~shreg_q[0];
              end else begin
                state_d = IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            count_d = '0;
            state_d = write_q ? WRITE_DATA : READ_DATA;
          end
          WRITE_DATA: begin
            count_d = count_q + 4'd1;
            if (count_q == BIT_LAST) state_d = WRITE_ACK;
          end
          WRITE_ACK: begin
            count_d = '0;
            state_d = WRITE_DATA;
          end
          READ_DATA: begin
            count_d = count_q + 4'd1;
            if (count_q == BIT_LAST) state_d = READ_ACK;
          end
          READ_ACK: begin
            // A controller NACK ends the read; wait for STOP or START.
            count_d = '0;
            state_d = mack_q ? IGNORE : READ_DATA;
          end
          default: ;  // IDLE and IGNORE hold; invalid codes handled below
        endcase
      end
    end else if (scl_rise) begin
      if (shifts_in(state_q)) shreg_d = {shreg_q[6:0], sda_s};
      if (state_q == READ_ACK) mack_d = sda_s;
    end

    if (!is_valid_state(state_d)) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // Protocol state machine registers; slot outputs are decoded from the
  // next state so they change together with i2c_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      mack_q      <= 1'b0;
      skip_fall_q <= 1'b0;
      sda_en_q    <= 1'b0;
      addr_ack_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      read_q      <= read_d;
      write_q     <= write_d;
      mack_q      <= mack_d;
      skip_fall_q <= skip_fall_d;
      sda_en_q    <= drives_sda(state_d);
      addr_ack_q  <= (state_d == ADDR_ACK);
      start_det_q <= bus_start & ~bus_stop;
      stop_det_q  <= bus_stop;
    end
  end

  assign i2c_state   = state_q;
  assign clock_count = count_q;
  assign read_bit    = read_q;
  assign write_bit   = write_q;
  assign sda_en      = sda_en_q;
  assign addr_ack    = addr_ack_q;
  assign start_det   = start_det_q;
  assign stop_det    = stop_det_q;

endmodule

// File: tb/tb_i2c_protocol_fsm.sv
// Directed bench for i2c_protocol_fsm: per-slot expectation tables for whole
// transactions plus hand-written bus-condition and reset sequences.
`timescale 1ns/1ps
module tb_i2c_protocol_fsm;

  localparam int Q = 5;  // clk cycles per SCL quarter period (SCL = clk/20)

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_AACK  = 4'd2;
  localparam logic [3:0] S_WDATA = 4'd3;
  localparam logic [3:0] S_WACK  = 4'd4;
  localparam logic [3:0] S_RDATA = 4'd5;
  localparam logic [3:0] S_RACK  = 4'd6;
  localparam logic [3:0] S_IGN   = 4'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic [3:0] i2c_state;
  logic [3:0] clock_count;
  logic       read_bit, write_bit, sda_en, addr_ack, start_det, stop_det;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int s0;

  // One bit slot: SDA driven by the controller, expected outputs while SCL high.
  typedef struct {
    logic       sda;
    logic [3:0] st;
    logic [3:0] cnt;
    logic       rd;
    logic       wr;
    logic       en;
    logic       ack;
  } slot_t;

  slot_t vec[$];

  i2c_protocol_fsm #(
    .SLAVE_ADDR (7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .i2c_state  (i2c_state),
    .clock_count(clock_count),
    .read_bit   (read_bit),
    .write_bit  (write_bit),
    .sda_en     (sda_en),
    .addr_ack   (addr_ack),
    .start_det  (start_det),
    .stop_det   (stop_det)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {i2c_state, clock_count, read_bit, write_bit, sda_en, addr_ack};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input logic sda, input logic [3:0] st, input logic [3:0] cnt,
                     input logic rd, input logic wr, input logic en, input logic ack);
    slot_t s;
    s.sda = sda; s.st = st; s.cnt = cnt; s.rd = rd; s.wr = wr; s.en = en; s.ack = ack;
    vec.push_back(s);
  endtask

  task automatic add_byte(input logic [7:0] b, input logic [3:0] st,
                          input logic rd, input logic wr, input logic en);
    for (int i = 0; i < 8; i++) add(b[7-i], st, 4'(i), rd, wr, en, 1'b0);
  endtask

  // Start from idle bus (SCL high); ends with SCL low.
  task automatic do_start();
    sda_in = 1'b1; scl_in = 1'b1; wait_clks(Q);
    sda_in = 1'b0; wait_clks(Q);
    scl_in = 1'b0; wait_clks(Q);
  endtask

  // Repeated START from SCL low; ends with SCL low.
  task automatic do_rstart();
    sda_in = 1'b1; wait_clks(Q);
    scl_in = 1'b1; wait_clks(Q);
    sda_in = 1'b0; wait_clks(Q);
    scl_in = 1'b0; wait_clks(Q);
  endtask

  // STOP from SCL low; ends with bus idle.
  task automatic do_stop();
    sda_in = 1'b0; wait_clks(Q);
    scl_in = 1'b1; wait_clks(Q);
    sda_in = 1'b1; wait_clks(Q);
  endtask

  // Apply queued slots one SCL period each, checking outputs mid SCL-high.
  task automatic run(input string tag);
    for (int i = 0; i < vec.size(); i++) begin
      sda_in = vec[i].sda; wait_clks(Q);
      scl_in = 1'b1;       wait_clks(Q);
      check($sformatf("%s[%0d]", tag, i), 32'(outs()),
            32'({vec[i].st, vec[i].cnt, vec[i].rd, vec[i].wr, vec[i].en, vec[i].ack}));
      wait_clks(Q);
      scl_in = 1'b0;       wait_clks(Q);
    end
    vec.delete();
  endtask

  initial begin
    // Reset state, during and after reset.
    wait_clks(3);
    check("rst_hold", 32'(outs()), 32'd0);
    check("rst_pulses", 32'({start_det, stop_det}), 32'd0);
    rst_n = 1'b1;
    wait_clks(10);
    check("rst_release", 32'(outs()), 32'd0);
    check("rst_no_start", 32'(start_cnt), 32'd0);

    // Write 0x84: data 0xA5, 0x3C.
    do_start();
    check("wr_start", 32'({i2c_state, clock_count}), 32'({S_ADDR, 4'd0}));
    check("wr_start_det", 32'(start_cnt), 32'd1);
    add_byte(8'h84, S_ADDR, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
    add_byte(8'hA5, S_WDATA, 1'b0, 1'b1, 1'b0);
    add(1'b1, S_WACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    add_byte(8'h3C, S_WDATA, 1'b0, 1'b1, 1'b0);
    add(1'b1, S_WACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    run("write");
    do_stop();
    check("wr_stop", 32'(outs()), 32'({S_IDLE, 4'd0, 4'b0000}));
    check("wr_stop_det", 32'(stop_cnt), 32'd1);

    // Address mismatch 0x86.
    do_start();
    add_byte(8'h86, S_ADDR, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) add(1'(i % 2), S_IGN, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    run("mismatch");
    do_stop();
    check("mm_stop", 32'(outs()), 32'({S_IDLE, 4'd0, 4'b0000}));
    check("mm_stop_det", 32'(stop_cnt), 32'd2);

    // Read 0x85: ACK after byte 1, NACK after byte 2.
    do_start();
    add_byte(8'h85, S_ADDR, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    add_byte(8'hFF, S_RDATA, 1'b1, 1'b0, 1'b1);
    add(1'b0, S_RACK, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    add_byte(8'hFF, S_RDATA, 1'b1, 1'b0, 1'b1);
    add(1'b1, S_RACK, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, S_IGN, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_IGN, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run("read");
    do_stop();
    check("rd_stop", 32'(outs()), 32'({S_IDLE, 4'd0, 4'b0000}));

    // Repeated START: write 0x84 + one byte, then START + 0x85.
    s0 = start_cnt;
    do_start();
    add_byte(8'h84, S_ADDR, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
    add_byte(8'h11, S_WDATA, 1'b0, 1'b1, 1'b0);
    add(1'b1, S_WACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    run("rs_write");
    do_rstart();
    check("rs_addr", 32'(outs()), 32'({S_ADDR, 4'd0, 4'b0100}));
    check("rs_start_det", 32'(start_cnt - s0), 32'd2);
    add_byte(8'h85, S_ADDR, 1'b0, 1'b1, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b1, S_RDATA, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run("rs_read");
    do_stop();
    check("rs_stop", 32'(outs()), 32'({S_IDLE, 4'd0, 4'b0000}));

    // STOP in the middle of a write byte, with exact latency.
    do_start();
    add_byte(8'h84, S_ADDR, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) add(1'(i % 2), S_WDATA, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    run("mid");
    check("mid_cnt", 32'({i2c_state, clock_count}), 32'({S_WDATA, 4'd4}));
    s0 = stop_cnt;
    sda_in = 1'b0; wait_clks(Q);
    scl_in = 1'b1; wait_clks(Q);
    sda_in = 1'b1; wait_clks(2);
    check("mid_pre_stop", 32'({i2c_state, stop_det}), 32'({S_WDATA, 1'b0}));
    wait_clks(1);
    check("mid_stop", 32'({outs(), stop_det}), 32'({S_IDLE, 4'd0, 4'b0000, 1'b1}));
    wait_clks(1);
    check("mid_stop_pulse", 32'(stop_det), 32'd0);
    check("mid_stop_cnt", 32'(stop_cnt - s0), 32'd1);
    wait_clks(Q);

    // Reset in the middle of a read byte.
    do_start();
    add_byte(8'h85, S_ADDR, 1'b0, 1'b0, 1'b0);
    add(1'b1, S_AACK, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b1, S_RDATA, 4'(i), 1'b1, 1'b0, 1'b1, 1'b0);
    run("rst_mid");
    check("rst_mid_cnt", 32'({i2c_state, clock_count, read_bit}), 32'({S_RDATA, 4'd3, 1'b1}));
    s0 = start_cnt;
    #1 rst_n = 1'b0;
    #1 check("rst_mid_async", 32'(outs()), 32'd0);
    sda_in = 1'b1;
    scl_in = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(10);
    check("rst_mid_release", 32'(outs()), 32'd0);
    check("rst_mid_no_start", 32'(start_cnt - s0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
